// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the time-multiplexed 61-tap FIR engine.
package fir_pkg;

  localparam int NTAPS     = 61;
  localparam int DATA_W    = 8;
  localparam int COEFF_W   = 10;
  localparam int ACC_W     = 24;
  localparam int BUF_DEPTH = 64;
  localparam int PTR_W     = 6;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_sample_buf.sv
// Circular sample history: one synchronous write port, one combinational read port.
module fir_sample_buf #(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int PTR_W  = fir_pkg::PTR_W
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**PTR_W];

  // NOTE: the array has no reset; the owner zero-fills it through the write port, so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir61_serial.sv
// Serial FIR: one multiply-accumulate per clock over a 64-entry circular sample history.
// Optional build macro FIR_OVERRUN_EN adds a sticky overrun flag for samples dropped while computing.
module fir61_serial #(
  parameter int NTAPS   = fir_pkg::NTAPS,
  parameter int DATA_W  = fir_pkg::DATA_W,
  parameter int COEFF_W = fir_pkg::COEFF_W,
  parameter int ACC_W   = fir_pkg::ACC_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ready,
  input  logic signed [DATA_W-1:0]  x,
  output logic [5:0]                index,
  input  logic signed [COEFF_W-1:0] coeff,
  output logic signed [ACC_W-1:0]   y,
  output logic                      done,
`ifdef FIR_OVERRUN_EN
  output logic                      overrun,
`endif
  output logic                      busy
);

  import fir_pkg::*;

  localparam int PROD_W = DATA_W + COEFF_W;
  localparam logic [PTR_W-1:0] LAST_TAP = PTR_W'(NTAPS - 1);
  localparam logic [PTR_W-1:0] LAST_CLR = PTR_W'(BUF_DEPTH - 1);

  fir_state_e state_q, state_d;
  logic [PTR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] newest_q, newest_d;
  logic [PTR_W-1:0] tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] y_q, y_d;
  logic done_q, done_d;

  logic              buf_we;
  logic [PTR_W-1:0]  buf_waddr, buf_raddr;
  logic [DATA_W-1:0] buf_wdata, buf_rdata;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;

  fir_sample_buf #(.DATA_W(DATA_W), .PTR_W(PTR_W)) u_buf (
    .clock   (clock),
    .we_i    (buf_we & ~reset),
    .waddr_i (buf_waddr),
    .wdata_i (buf_wdata),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  // Tap k reads x[n-k]; the 6-bit subtraction wraps through the circular buffer.
  assign buf_raddr = newest_q - tap_q;
  assign prod      = PROD_W'(coeff) * PROD_W'($signed(buf_rdata));
  assign acc_sum   = acc_q + ACC_W'(prod);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    newest_d  = newest_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    y_d       = y_q;
    done_d    = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = wr_ptr_q;
    buf_wdata = x;
    unique case (state_q)
      CLEAR: begin
        buf_we    = 1'b1;
        buf_waddr = clr_cnt_q;
        buf_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_CLR) state_d = IDLE;
      end
      IDLE: begin
        if (ready) begin
          buf_we   = 1'b1;
          newest_d = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + 1'b1;
          acc_d    = '0;
          tap_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        tap_d = tap_q + 1'b1;
        // y and done are registered together so they appear in the DONE cycle.
        if (tap_q == LAST_TAP) begin
          y_d     = acc_sum;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      wr_ptr_q  <= '0;
      newest_q  <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      newest_q  <= newest_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      done_q    <= done_d;
    end
  end

  assign index = (state_q == MAC) ? tap_q : '0;
  assign busy  = (state_q != IDLE);
  assign y     = y_q;
  assign done  = done_q;

`ifdef FIR_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (ready && (state_q == MAC || state_q == DONE)) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule
